// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    // One decoded key event as stored in the FIFO (10 bits).
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Event stream from the PS/2 receiver to its consumer (FWFT valid/ready plus occupancy).
interface ps2_scan_receiver_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    event_code;
    logic          event_ext;
    logic          event_break;
    logic          event_valid;
    logic          event_ready;
    logic [CW-1:0] fifo_count;

    modport master (
        output event_code, event_ext, event_break, event_valid, fifo_count,
        input  event_ready
    );

    modport slave (
        input  event_code, event_ext, event_break, event_valid, fifo_count,
        output event_ready
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is dropped unless a pop coincides.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clock_50,
    input  logic                          Resetn,
    input  logic                          push_i,
    input  ps2_event_t                    push_data_i,
    input  logic                          pop_i,
    output ps2_event_t                    head_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    ps2_event_t  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;

    logic do_pop, do_push, full;

    assign full    = (count_q == FULL_COUNT);
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full || do_pop);

    // Pointers are AW bits wide so they wrap modulo the power-of-two depth.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_i && full && !do_pop;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge Clock_50) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Head is forced to zero when empty so stale storage never shows on the port.
    assign valid_o    = (count_q != '0);
    assign head_o     = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 frame receiver with E0/F0 prefix folding and an event FIFO.
// Define PS2_PARITY_CHECK_EN to discard bytes with bad odd parity (err_pulse[0]).
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                       Clock_50,
    input  logic                       Resetn,
    input  logic                       PS2_clock,
    input  logic                       PS2_data,
    ps2_scan_receiver_if.master        evt,
    output logic [2:0]                 err_pulse,
    output logic                       overflow
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall, bit_in;

    ps2_state_e      state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [WD_W-1:0] wd_q;
    logic            ext_q, brk_q;
    logic [2:0]      err_q;
    logic            parity_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic            par_ok_q;
`endif

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_clock};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_data};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev_q && !clk_sync_q[SYNC_STAGES-1];
    assign bit_in = dat_sync_q[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = par_ok_q;
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wd_q      <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            err_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
            par_ok_q  <= 1'b0;
`endif
        end else begin
            err_q <= '0;
            if (state_q == ST_IDLE) begin
                wd_q <= '0;
                if (fall && !bit_in) begin
                    state_q   <= ST_DATA;
                    bit_cnt_q <= '0;
                end
            end else if (fall) begin
                wd_q <= '0;
                unique case (state_q)
                    ST_DATA: begin
                        shift_q   <= {bit_in, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_ok_q <= ps2_odd_parity_ok(shift_q, bit_in);
`endif
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        // Framing beats parity: a bad stop bit reports only [1].
                        if (!bit_in)                        err_q[1] <= 1'b1;
                        else if (!parity_ok)                err_q[0] <= 1'b1;
                        else if (shift_q == PS2_PREFIX_EXT)   ext_q <= 1'b1;
                        else if (shift_q == PS2_PREFIX_BREAK) brk_q <= 1'b1;
                        else begin
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (wd_q == WD_LAST) begin
                state_q <= ST_IDLE;
                wd_q    <= '0;
                ext_q   <= 1'b0;
                brk_q   <= 1'b0;
                err_q   <= 3'b100;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end

    // Push is decoded from the stop-bit edge itself so the FIFO write lands at the end of that cycle.
    logic       push;
    ps2_event_t push_data, head;

    assign push = (state_q == ST_STOP) && fall && bit_in && parity_ok
                  && (shift_q != PS2_PREFIX_EXT) && (shift_q != PS2_PREFIX_BREAK);
    assign push_data = '{ext: ext_q, brk: brk_q, code: shift_q};

    logic                         fifo_valid;
    logic [$clog2(FIFO_DEPTH):0]  fifo_cnt;

    ps2_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .Clock_50   (Clock_50),
        .Resetn     (Resetn),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (evt.event_ready),
        .head_o     (head),
        .valid_o    (fifo_valid),
        .count_o    (fifo_cnt),
        .overflow_o (overflow)
    );

    assign evt.event_code  = head.code;
    assign evt.event_ext   = head.ext;
    assign evt.event_break = head.brk;
    assign evt.event_valid = fifo_valid;
    assign evt.fifo_count  = fifo_cnt;
    assign err_pulse       = err_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: directed scenarios plus random frames vs. a prefix-folding model.
module tb_ps2_scan_receiver;
    import ps2_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int SYNC  = 2;
    localparam int HALF  = 10;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    logic       Clock_50 = 1'b0;
    logic       Resetn   = 1'b0;
    logic       PS2_clock = 1'b1;
    logic       PS2_data  = 1'b1;
    logic [2:0] err_pulse;
    logic       overflow;

    ps2_scan_receiver_if #(.FIFO_DEPTH(DEPTH)) evt ();

    ps2_scan_receiver #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .Clock_50 (Clock_50),
        .Resetn   (Resetn),
        .PS2_clock(PS2_clock),
        .PS2_data (PS2_data),
        .evt      (evt),
        .err_pulse(err_pulse),
        .overflow (overflow)
    );

    always #10 Clock_50 = ~Clock_50;

    int vectors = 0, miscompares = 0;
    int cycle_cnt = 0;
    always @(posedge Clock_50) cycle_cnt++;

    logic [9:0] exp_evt_q[$];
    logic [2:0] exp_err_q[$];
    int  exp_ovf = 0, seen_ovf = 0;
    bit  m_ext = 1'b0, m_brk = 1'b0;
    bit  check_lat = 1'b0;
    int  stop_cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else
            $display("pass %s: %0h", name, act);
    endtask

    task automatic fail_unexpected(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Reference: a frame yields an error, a prefix flag update, or one event {ext,brk,code}.
    task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        if (stop_bad)
            exp_err_q.push_back(3'b010);
        else if (par_bad && PARITY_ON)
            exp_err_q.push_back(3'b001);
        else if (b == 8'hE0)
            m_ext = 1'b1;
        else if (b == 8'hF0)
            m_brk = 1'b1;
        else begin
            if (exp_evt_q.size() >= DEPTH) exp_ovf++;
            else exp_evt_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clock_50);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit mark_last);
        for (int i = 0; i < n; i++) begin
            wait_cyc(HALF);
            PS2_data = bits[i];
            wait_cyc(HALF);
            PS2_clock = 1'b0;
            if (mark_last && i == n - 1) stop_cycle = cycle_cnt;
            wait_cyc(HALF);
            PS2_clock = 1'b1;
        end
        wait_cyc(HALF);
        PS2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
        logic par, stp;
        model_frame(b, par_bad, stop_bad);
        par = ~(^b) ^ par_bad;
        stp = ~stop_bad;
        send_bits({stp, par, b, 1'b0}, 11, 1'b1);
        wait_cyc(3 * HALF);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"},  {24'd0, evt.event_code}, 32'd0);
        check({tag, "_ext"},   {31'd0, evt.event_ext}, 32'd0);
        check({tag, "_brk"},   {31'd0, evt.event_break}, 32'd0);
        check({tag, "_valid"}, {31'd0, evt.event_valid}, 32'd0);
        check({tag, "_count"}, 32'(evt.fifo_count), 32'd0);
        check({tag, "_err"},   {29'd0, err_pulse}, 32'd0);
        check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    endtask

    task automatic drain(input string tag);
        wait_cyc(60);
        check({tag, "_evt_left"}, exp_evt_q.size(), 32'd0);
        check({tag, "_err_left"}, exp_err_q.size(), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands over an event or raises a pulse.
    always @(negedge Clock_50) begin
        if (Resetn) begin
            if (evt.event_valid && evt.event_ready) begin
                if (exp_evt_q.size() == 0)
                    fail_unexpected("event", {22'd0, evt.event_ext, evt.event_break, evt.event_code});
                else begin
                    check("event", {22'd0, evt.event_ext, evt.event_break, evt.event_code},
                          {22'd0, exp_evt_q.pop_front()});
                    if (check_lat) begin
                        check("latency", cycle_cnt - stop_cycle, SYNC + 1);
                        check_lat = 1'b0;
                    end
                end
            end
            if (err_pulse != 3'b000) begin
                if (exp_err_q.size() == 0) fail_unexpected("err_pulse", {29'd0, err_pulse});
                else check("err_pulse", {29'd0, err_pulse}, {29'd0, exp_err_q.pop_front()});
            end
            if (overflow) seen_ovf++;
        end
    end

    initial begin
        logic [7:0] rb;
        int         r;
        bit         pb, sb;
        logic [7:0] ovf_codes [5];

        evt.event_ready = 1'b1;

        repeat (3) @(negedge Clock_50);
        check_reset_outputs("reset");
        wait_cyc(2);
        Resetn = 1'b1;
        wait_cyc(5);

        check_lat = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b0);
        drain("basic");

        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        drain("prefix");

        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1);
        drain("parity");

        // Watchdog: E0 then a stalled frame; flags must be cleared by the timeout.
        send_frame(8'hE0, 1'b0, 1'b0);
        exp_err_q.push_back(3'b100);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_bits({6'b111111, 4'b1010, 1'b0}, 5, 1'b0);
        wait_cyc(TMO + 50);
        send_frame(8'h29, 1'b0, 1'b0);
        drain("timeout");

        // Reset after 6 data bits, with an E0 prefix pending.
        send_frame(8'hE0, 1'b0, 1'b0);
        send_bits({4'b1111, 6'b110101, 1'b0}, 7, 1'b0);
        Resetn = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        repeat (2) @(negedge Clock_50);
        check_reset_outputs("midreset");
        wait_cyc(2);
        Resetn = 1'b1;
        wait_cyc(5);
        send_frame(8'h5A, 1'b0, 1'b0);
        drain("midreset");

        // Overflow: five codes into a depth-4 FIFO with the consumer stalled.
        ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        evt.event_ready = 1'b0;
        seen_ovf = 0;
        exp_ovf  = 0;
        for (int i = 0; i < 5; i++) send_frame(ovf_codes[i], 1'b0, 1'b0);
        @(negedge Clock_50);
        check("ovf_count", 32'(evt.fifo_count), DEPTH);
        check("ovf_pulses", seen_ovf, exp_ovf);
        check("ovf_head", {24'd0, evt.event_code}, {24'd0, ovf_codes[0]});
        wait_cyc(1);
        evt.event_ready = 1'b1;
        drain("overflow");

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            rb = 8'($urandom_range(0, 255));
            if (r < 2) rb = 8'hE0;
            else if (r < 4) rb = 8'hF0;
            pb = ($urandom_range(0, 7) == 0);
            sb = ($urandom_range(0, 9) == 0);
            send_frame(rb, pb, sb);
        end
        drain("random");
        check("total_ovf", seen_ovf, exp_ovf);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth; power of two, 2..64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum Clock_50 cycles between PS/2 clock falling edges inside a frame.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for PS2_clock and PS2_data; minimum 2.
REQ-004 SHALL have port Clock_50  input  1  system clock, 50 MHz.
REQ-005 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port PS2_clock  input  1  raw PS/2 clock, asynchronous.
REQ-007 SHALL have port PS2_data  input  1  raw PS/2 data, asynchronous.
REQ-008 SHALL have port event_code  output  8  scan code at FIFO head.
REQ-009 SHALL have port event_ext  output  1  head event was preceded by an E0 prefix.
REQ-010 SHALL have port event_break  output  1  head event was preceded by an F0 prefix (key release).
REQ-011 SHALL have port event_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port event_ready  input  1  consumer pops the head when event_valid is high.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-014 SHALL have port err_pulse  output  3  one-cycle pulses: [0] parity, [1] framing, [2] timeout.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse when an event is dropped.

Function
REQ-016 SHALL synchronise both PS/2 inputs through SYNC_STAGES flops and detect a PS/2 clock falling edge as previous=1, current=0.
REQ-017 SHALL sample synchronised data only on detected falling edges.
REQ-018 SHALL implement FSM IDLE→DATA on data=0 (start bit), DATA→PARITY after 8 bits LSB-first, PARITY→STOP, STOP→IDLE on the next edge.
REQ-019 SHALL ignore data=1 edges in IDLE.
REQ-020 SHALL check odd parity over the 8 data bits plus the parity bit; on mismatch, discard the byte and pulse err_pulse[0] on the stop-bit edge cycle.
REQ-021 SHALL treat stop bit=0 as a framing error: discard the byte, pulse err_pulse[1], return to IDLE; framing takes precedence when both errors occur (single pulse, [1] only).
REQ-022 SHALL run a watchdog counter outside IDLE, cleared on every edge; on reaching TIMEOUT_CYCLES it SHALL force IDLE, clear the prefix flags and pulse err_pulse[2].
REQ-023 SHALL set ext_flag and emit no event on a good byte 8'hE0.
REQ-024 SHALL set break_flag and emit no event on a good byte 8'hF0.
REQ-025 SHALL push {ext_flag, break_flag, byte} on any other good byte and then clear both flags.
REQ-026 SHALL write the FIFO at the end of the stop-bit edge cycle N; event_valid/head SHALL be visible in cycle N+1 when the FIFO was empty.
REQ-027 SHALL use a first-word-fall-through FIFO: head outputs are valid whenever event_valid=1, and the pop occurs on the clock where event_valid&event_ready.
REQ-028 SHALL drop a push to a full FIFO without a simultaneous pop, pulse overflow and leave contents unchanged.
REQ-029 SHALL accept both operations when push and pop coincide while full, leaving fifo_count unchanged.
REQ-030 SHALL ignore event_ready when the FIFO is empty.
REQ-031 SHALL wrap read/write pointers modulo FIFO_DEPTH.

Reset
REQ-032 SHALL on Resetn=0 force state IDLE; clear the FIFO, pointers, flags, watchdog and synchronisers (to 1); and drive outputs event_code=0, event_ext=0, event_break=0, event_valid=0, fifo_count=0, err_pulse=0, overflow=0.
REQ-033 SHALL discard a partially received frame on reset mid-frame and emit no error pulse.

Configuration
REQ-034 SHALL honour macro PS2_PARITY_CHECK_EN: when defined, apply REQ-020; when undefined, ignore the parity bit, tie err_pulse[0] to 0 and accept the byte.

Structure
REQ-035 SHALL place the FSM state enum, constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BREAK=8'hF0, and the 10-bit event struct in package ps2_pkg.
REQ-036 SHALL implement the FIFO as sub-module ps2_event_fifo (parameter FIFO_DEPTH).

Verification
REQ-037 SHALL cover: frame 0x1C with good parity, event_ready=1 → one event {ext=0, brk=0, code=0x1C}, event_valid one cycle after the stop edge.
REQ-038 SHALL cover: bytes E0,F0,75 → exactly one event {ext=1, brk=1, code=0x75}; next byte 75 → {0,0,0x75}.
REQ-039 SHALL cover: 0x1C with flipped parity → no event, err_pulse=3'b001 (macro on); event {0,0,0x1C} (macro off).
REQ-040 SHALL cover: start, 4 bits, then clock idle for TIMEOUT_CYCLES → err_pulse=3'b100, state IDLE, and a following good 0x29 is received correctly.
REQ-041 SHALL cover: FIFO_DEPTH=4, event_ready=0, 5 codes → fifo_count=4, overflow pulse on the 5th, and pops return the first 4 codes in order.
REQ-042 SHALL cover: Resetn pulsed after 6 data bits → no event, no error, all outputs 0, and the next full frame decodes.
